// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the round-robin stream multiplexer.
// Used by rr_arbiter and rr_stream_mux.
package rr_mux_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [sel_w(DEF_N)-1:0] idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts after the last grant.
// RR_STREAM_MUX_FIXED_PRIO_EN makes channel 0 the fixed highest priority.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  int start;

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
  assign start = 0;
`else
  assign start = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
`endif

  assign any = |req;

  always_comb begin
    logic found;
    int   c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = start + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = enable;
        idx      = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin arbitration and registered output.
// Define RR_STREAM_MUX_FIXED_PRIO_EN for fixed (lowest index wins) priority.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic             load;
  logic             any;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] gidx;
  logic [SEL_W-1:0] last;

  assign load = ~out_valid | out_ready;

  rr_arbiter #(
    .N    (N),
    .SEL_W(SEL_W)
  ) u_arb (
    .req   (in_valid),
    .last  (last),
    .enable(load & rst_n),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign in_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[int'(gidx)*WIDTH +: WIDTH];
        out_sel  <= gidx;
      end
    end
  end

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
  assign last = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= SEL_W'(N - 1);
    else if (load && any) last <= gidx;
  end
`endif

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N:1 stream multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage.
- Next-generation successor to the combinational 2:1 select. Shares one downstream consumer (e.g. a memory or bus port) among N requesters (fetch, load/store, debug).
- Output is registered: 1-cycle latency, full throughput of 1 transfer/cycle.

Parameters:
- WIDTH, 32: data width per channel in bits.
- N, 4: number of input channels, N >= 1.
- SEL_W, (N>1 ? $clog2(N) : 1): width of the channel index. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  packed input data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational, at most one bit set.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_sel  output  SEL_W  registered index of the channel held in the output register.

Behaviour:
- Reset: asynchronous on rst_n low. Values while reset is asserted:
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last=N-1, so the first search starts at channel 0.
  - in_ready is all zeros.
- Load enable: load = ~out_valid | out_ready. The output register is empty or is being drained this cycle.
- Arbitration (combinational):
  - Search channels starting at (last+1) mod N, wrapping through N-1 to 0.
  - Grant goes to the first channel with in_valid=1.
  - any = |in_valid.
- Handshake:
  - in_ready[i] = load & any & grant[i].
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
  - in_ready may depend on in_valid; upstream in_valid must not depend on in_ready (no combinational loop).
- Register update on clk rising edge:
  - If load & any: out_data <= granted data, out_sel <= grant index, out_valid <= 1, last <= grant index.
  - Else if load & ~any: out_valid <= 0. out_data and out_sel hold their values. last holds.
  - Else (out_valid & ~out_ready, stall): all registers hold. out_data and out_sel stay stable while out_valid=1 and not accepted.
- Latency and throughput: accepted input appears on the output the next cycle. Back-to-back transfers sustain 1/cycle when out_ready stays 1.
- Fairness:
  - With all N channels continuously valid, grants rotate 0,1,...,N-1,0,...
  - No channel waits more than N-1 grants.
- Boundary conditions:
  - Pointer wrap from N-1 to 0 is a modulo increment, including N not a power of two.
  - Single valid channel is granted every cycle regardless of pointer.
  - N=1: grant=valid, out_sel always 0.
  - Simultaneous drain and refill in the same cycle is allowed; no bubble.
  - Reset asserted mid-transfer discards the held word. No partial state survives.

Optional Feature:
- Macro: RR_STREAM_MUX_FIXED_PRIO_EN.
- Defined: the pointer register is removed and the search always starts at channel 0, so the lowest index wins (fixed priority). Starvation of high indices is permitted.
- Undefined: round-robin as specified above.
- All other behaviour, ports and latency are identical in both builds.

Decomposition:
- Shared package rr_mux_pkg:
  - default WIDTH and N constants;
  - a clog2-based SEL_W helper function;
  - a typedef for the channel index.
- One sub-module, rr_arbiter:
  - inputs: req[N], last index, enable;
  - outputs: one-hot grant, grant index, any;
  - purely combinational.
- The top level holds the output register and the pointer.

Test Plan (WIDTH=32, N=4):
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000. Release -> first grant is channel 0 (in_ready=0001).
- Rotation: all in_valid=1, in_data[i]=32'hA0+i, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; out_sel 0,1,2,3,0.
- Stall: out_valid=1 holding 32'hA2, out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0000. Then out_ready=1 -> same-cycle refill with channel 3.
- Sparse: only channel 2 valid for 5 cycles -> granted every cycle. Then channels 1 and 3 valid -> channel 3 is granted first (search starts after last=2).
- Empty drain: no in_valid, out_ready=1 -> out_valid falls to 0 the next cycle; out_data retains its last value.
- Mid-op reset: assert rst_n low while out_valid=1 -> out_valid=0 immediately (async); after release, arbitration restarts at channel 0.
- With RR_STREAM_MUX_FIXED_PRIO_EN: all valid -> channel 0 is granted every cycle.
